// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter:
//   owner_t        : tag of the port whose read response is in flight
//   STARVE_MAX_DEF : default number of denied port-B cycles before B is forced
//   SCNT_W         : width of the starvation counter (covers MAX up to 15)
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    localparam int STARVE_MAX_DEF = 4;
    localparam int SCNT_W         = 4;

endpackage : dmem_arb_pkg

// File: rtl/arb_starve_cnt.sv
// -----------------------------------------------------------------------------
// arb_starve_cnt
// Saturating count of consecutive cycles a requester has been denied.
// Ports:
//   clk    : clock, state on rising edge
//   rst    : asynchronous active-high reset (count -> 0)
//   wait_i : requester is waiting (denied) this cycle -> count up
//   clr_i  : requester idle or granted this cycle -> count clears (wins over wait_i)
//   sat_o  : count has reached MAX
// -----------------------------------------------------------------------------
module arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic wait_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam logic [SCNT_W-1:0] MAX_C = SCNT_W'(MAX);

    logic [SCNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (wait_i && (r_cnt != MAX_C)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign sat_o = (r_cnt == MAX_C);

endmodule : arb_starve_cnt

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port synchronous memory (1-cycle read latency) between the
// core's MM-stage data port (A, priority) and a host/debug port (B). B is
// forced to win after STARVE_MAX consecutive denied cycles.
// Ports:
//   clk, rst                     : clock / asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata    : port A request (held until a_gnt)
//   a_gnt                        : port A granted this cycle (combinational)
//   a_rvalid/a_rdata             : port A read response, one cycle after grant
//   b_*                          : same set for port B
//   m_addr/m_in/m_we             : drive to memory (zero when nobody is granted)
//   m_out                        : memory read data, valid one cycle after m_addr
//   starved                      : B-priority state active
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int AW         = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_req,
    input  logic             a_we,
    input  logic [AW-1:0]    a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    output logic             a_gnt,
    output logic             a_rvalid,
    output logic [WIDTH-1:0] a_rdata,
    input  logic             b_req,
    input  logic             b_we,
    input  logic [AW-1:0]    b_addr,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             b_gnt,
    output logic             b_rvalid,
    output logic [WIDTH-1:0] b_rdata,
    output logic [AW-1:0]    m_addr,
    output logic [WIDTH-1:0] m_in,
    output logic             m_we,
    input  logic [WIDTH-1:0] m_out,
    output logic             starved
);

    logic             w_starved;
    logic             w_a_gnt;
    logic             w_b_gnt;
    owner_t           r_owner;
    logic [WIDTH-1:0] r_a_rdata;
    logic [WIDTH-1:0] r_b_rdata;

    // Grants are suppressed while reset is held so the memory side sees no
    // access and no owner tag can be captured.
    assign w_b_gnt = !rst && b_req && (!a_req || w_starved);
    assign w_a_gnt = !rst && a_req && !w_b_gnt;

    assign a_gnt   = w_a_gnt;
    assign b_gnt   = w_b_gnt;
    assign starved = w_starved;

    arb_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk    (clk),
        .rst    (rst),
        .wait_i (b_req && !w_b_gnt),
        .clr_i  (!b_req || w_b_gnt),
        .sat_o  (w_starved)
    );

    always_comb begin
        m_addr = '0;
        m_in   = '0;
        m_we   = 1'b0;
        if (w_a_gnt) begin
            m_addr = a_addr;
            m_in   = a_wdata;
            m_we   = a_we;
        end else if (w_b_gnt) begin
            m_addr = b_addr;
            m_in   = b_wdata;
            m_we   = b_we;
        end
    end

    // Only reads are tagged; writes leave the tag at NONE so no response pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= OWN_NONE;
        end else if (w_a_gnt && !a_we) begin
            r_owner <= OWN_A;
        end else if (w_b_gnt && !b_we) begin
            r_owner <= OWN_B;
        end else begin
            r_owner <= OWN_NONE;
        end
    end

    // Hold registers keep each port's last delivered word once its pulse ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            if (r_owner == OWN_A) begin
                r_a_rdata <= m_out;
            end
            if (r_owner == OWN_B) begin
                r_b_rdata <= m_out;
            end
        end
    end

    // During the response cycle the memory output is forwarded directly, since
    // the memory itself provides the one cycle of read latency.
    assign a_rvalid = (r_owner == OWN_A);
    assign b_rvalid = (r_owner == OWN_B);
    assign a_rdata  = a_rvalid ? m_out : r_a_rdata;
    assign b_rdata  = b_rvalid ? m_out : r_b_rdata;

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we;
    logic [31:0] a_addr, a_wdata;
    logic        a_gnt, a_rvalid;
    logic [31:0] a_rdata;
    logic        b_req, b_we;
    logic [31:0] b_addr, b_wdata;
    logic        b_gnt, b_rvalid;
    logic [31:0] b_rdata;
    logic [31:0] m_addr, m_in, m_out;
    logic        m_we;
    logic        starved;

    logic        mem_load;
    logic [31:0] mem [0:63];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Behavioural single-port synchronous memory, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 | i;
            mem[5] <= 32'hDEAD_BEEF;
            m_out  <= 32'h0;
        end else begin
            if (m_we) mem[m_addr[5:0]] <= m_in;
            m_out <= mem[m_addr[5:0]];
        end
    end

    dmem_arbiter #(
        .WIDTH      (32),
        .AW         (32),
        .STARVE_MAX (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .m_addr   (m_addr),
        .m_in     (m_in),
        .m_we     (m_we),
        .m_out    (m_out),
        .starved  (starved)
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_load = 1'b1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'd5; a_wdata = 32'h55;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'd6; b_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (a_gnt !== 1'b0)    begin bad++; $display("FAIL reset_a_gnt got=%0h exp=0", a_gnt); end
        total++; if (b_gnt !== 1'b0)    begin bad++; $display("FAIL reset_b_gnt got=%0h exp=0", b_gnt); end
        total++; if (m_we !== 1'b0)     begin bad++; $display("FAIL reset_m_we got=%0h exp=0", m_we); end
        total++; if (m_addr !== 32'h0)  begin bad++; $display("FAIL reset_m_addr got=%0h exp=0", m_addr); end
        total++; if (m_in !== 32'h0)    begin bad++; $display("FAIL reset_m_in got=%0h exp=0", m_in); end
        total++; if (a_rvalid !== 1'b0) begin bad++; $display("FAIL reset_a_rvalid got=%0h exp=0", a_rvalid); end
        total++; if (b_rvalid !== 1'b0) begin bad++; $display("FAIL reset_b_rvalid got=%0h exp=0", b_rvalid); end
        total++; if (a_rdata !== 32'h0) begin bad++; $display("FAIL reset_a_rdata got=%0h exp=0", a_rdata); end
        total++; if (b_rdata !== 32'h0) begin bad++; $display("FAIL reset_b_rdata got=%0h exp=0", b_rdata); end
        total++; if (starved !== 1'b0)  begin bad++; $display("FAIL reset_starved got=%0h exp=0", starved); end
        $display("reset: outputs checked under reset");
        next_cycle();
        rst = 1'b0; mem_load = 1'b0;
        a_req = 1'b0; a_we = 1'b0; b_req = 1'b0;
    endtask

    task automatic test_a_read;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd5;
        @(negedge clk);
        total++; if (a_gnt !== 1'b1)    begin bad++; $display("FAIL aread_gnt got=%0h exp=1", a_gnt); end
        total++; if (b_gnt !== 1'b0)    begin bad++; $display("FAIL aread_b_gnt got=%0h exp=0", b_gnt); end
        total++; if (m_addr !== 32'd5)  begin bad++; $display("FAIL aread_m_addr got=%0h exp=5", m_addr); end
        total++; if (m_we !== 1'b0)     begin bad++; $display("FAIL aread_m_we got=%0h exp=0", m_we); end
        next_cycle();
        a_req = 1'b0;
        @(negedge clk);
        total++; if (a_rvalid !== 1'b1) begin bad++; $display("FAIL aread_rvalid got=%0h exp=1", a_rvalid); end
        total++; if (a_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL aread_rdata got=%0h exp=deadbeef", a_rdata); end
        total++; if (b_rvalid !== 1'b0) begin bad++; $display("FAIL aread_b_rvalid got=%0h exp=0", b_rvalid); end
        next_cycle();
        @(negedge clk);
        total++; if (a_rvalid !== 1'b0) begin bad++; $display("FAIL aread_rvalid_pulse got=%0h exp=0", a_rvalid); end
        total++; if (a_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL aread_rdata_hold got=%0h exp=deadbeef", a_rdata); end
        $display("a_read: addr 5 -> %08h", a_rdata);
        next_cycle();
    endtask

    task automatic test_b_write;
        b_req = 1'b1; b_we = 1'b1; b_addr = 32'd7; b_wdata = 32'h1234;
        @(negedge clk);
        total++; if (b_gnt !== 1'b1)     begin bad++; $display("FAIL bwrite_gnt got=%0h exp=1", b_gnt); end
        total++; if (m_we !== 1'b1)      begin bad++; $display("FAIL bwrite_m_we got=%0h exp=1", m_we); end
        total++; if (m_addr !== 32'd7)   begin bad++; $display("FAIL bwrite_m_addr got=%0h exp=7", m_addr); end
        total++; if (m_in !== 32'h1234)  begin bad++; $display("FAIL bwrite_m_in got=%0h exp=1234", m_in); end
        next_cycle();
        b_req = 1'b0; b_we = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd7;
        @(negedge clk);
        total++; if (b_rvalid !== 1'b0)  begin bad++; $display("FAIL bwrite_no_rvalid got=%0h exp=0", b_rvalid); end
        total++; if (a_gnt !== 1'b1)     begin bad++; $display("FAIL bwrite_a_gnt got=%0h exp=1", a_gnt); end
        next_cycle();
        a_req = 1'b0;
        @(negedge clk);
        total++; if (a_rvalid !== 1'b1)  begin bad++; $display("FAIL bwrite_readback_rvalid got=%0h exp=1", a_rvalid); end
        total++; if (a_rdata !== 32'h1234) begin bad++; $display("FAIL bwrite_readback got=%0h exp=1234", a_rdata); end
        $display("b_write: addr 7 readback %08h", a_rdata);
        next_cycle();
    endtask

    task automatic test_starve;
        logic exp_b;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'd2;
        for (int c = 0; c < 10; c++) begin
            exp_b = ((c % 5) == 4);
            @(negedge clk);
            total++; if (b_gnt !== exp_b)   begin bad++; $display("FAIL starve_b_gnt c=%0d got=%0h exp=%0h", c, b_gnt, exp_b); end
            total++; if (a_gnt !== !exp_b)  begin bad++; $display("FAIL starve_a_gnt c=%0d got=%0h exp=%0h", c, a_gnt, !exp_b); end
            total++; if (starved !== exp_b) begin bad++; $display("FAIL starve_flag c=%0d got=%0h exp=%0h", c, starved, exp_b); end
            $display("starve: cycle %0d a_gnt=%0b b_gnt=%0b starved=%0b", c, a_gnt, b_gnt, starved);
            next_cycle();
        end
        a_req = 1'b0; b_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_back_to_back;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd1;
        @(negedge clk);
        total++; if (a_gnt !== 1'b1) begin bad++; $display("FAIL b2b_a_gnt got=%0h exp=1", a_gnt); end
        next_cycle();
        a_req = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'd2;
        @(negedge clk);
        total++; if (a_rvalid !== 1'b1) begin bad++; $display("FAIL b2b_a_rvalid got=%0h exp=1", a_rvalid); end
        total++; if (a_rdata !== 32'hA000_0001) begin bad++; $display("FAIL b2b_a_rdata got=%0h exp=a0000001", a_rdata); end
        total++; if (b_rvalid !== 1'b0) begin bad++; $display("FAIL b2b_b_rvalid_early got=%0h exp=0", b_rvalid); end
        total++; if (b_gnt !== 1'b1)    begin bad++; $display("FAIL b2b_b_gnt got=%0h exp=1", b_gnt); end
        next_cycle();
        // A write right behind B's read must not disturb B's response.
        b_req = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'd2; a_wdata = 32'h5555_0000;
        @(negedge clk);
        total++; if (b_rvalid !== 1'b1) begin bad++; $display("FAIL b2b_b_rvalid got=%0h exp=1", b_rvalid); end
        total++; if (b_rdata !== 32'hA000_0002) begin bad++; $display("FAIL b2b_b_rdata got=%0h exp=a0000002", b_rdata); end
        total++; if (a_rvalid !== 1'b0) begin bad++; $display("FAIL b2b_a_rvalid_late got=%0h exp=0", a_rvalid); end
        total++; if (a_rdata !== 32'hA000_0001) begin bad++; $display("FAIL b2b_a_rdata_hold got=%0h exp=a0000001", a_rdata); end
        next_cycle();
        a_req = 1'b0; a_we = 1'b0;
        @(negedge clk);
        total++; if (b_rvalid !== 1'b0) begin bad++; $display("FAIL b2b_write_no_rvalid got=%0h exp=0", b_rvalid); end
        total++; if (a_rvalid !== 1'b0) begin bad++; $display("FAIL b2b_write_no_a_rvalid got=%0h exp=0", a_rvalid); end
        total++; if (b_rdata !== 32'hA000_0002) begin bad++; $display("FAIL b2b_b_rdata_hold got=%0h exp=a0000002", b_rdata); end
        $display("back_to_back: a_rdata=%08h b_rdata=%08h", a_rdata, b_rdata);
        next_cycle();
    endtask

    task automatic test_reset_mid_read;
        logic exp_b;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd5;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'd2;
        // Build the starvation count up to 3, then reset on the edge after an A read grant.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++; if (a_gnt !== 1'b1) begin bad++; $display("FAIL midrst_pre_a_gnt c=%0d got=%0h exp=1", c, a_gnt); end
            if (c < 3) next_cycle();
        end
        @(posedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++; if (a_rvalid !== 1'b0) begin bad++; $display("FAIL midrst_a_rvalid k=%0d got=%0h exp=0", k, a_rvalid); end
            total++; if (a_gnt !== 1'b0)    begin bad++; $display("FAIL midrst_a_gnt k=%0d got=%0h exp=0", k, a_gnt); end
            total++; if (b_gnt !== 1'b0)    begin bad++; $display("FAIL midrst_b_gnt k=%0d got=%0h exp=0", k, b_gnt); end
            total++; if (m_addr !== 32'h0)  begin bad++; $display("FAIL midrst_m_addr k=%0d got=%0h exp=0", k, m_addr); end
            total++; if (a_rdata !== 32'h0) begin bad++; $display("FAIL midrst_a_rdata k=%0d got=%0h exp=0", k, a_rdata); end
            total++; if (starved !== 1'b0)  begin bad++; $display("FAIL midrst_starved k=%0d got=%0h exp=0", k, starved); end
        end
        next_cycle();
        rst = 1'b0;
        // Counter restarted from 0: B needs four fresh denied cycles again.
        for (int c = 0; c < 5; c++) begin
            exp_b = (c == 4);
            @(negedge clk);
            if (c == 0) begin
                total++; if (a_rvalid !== 1'b0) begin bad++; $display("FAIL midrst_post_a_rvalid got=%0h exp=0", a_rvalid); end
            end
            total++; if (b_gnt !== exp_b)   begin bad++; $display("FAIL midrst_post_b_gnt c=%0d got=%0h exp=%0h", c, b_gnt, exp_b); end
            total++; if (starved !== exp_b) begin bad++; $display("FAIL midrst_post_starved c=%0d got=%0h exp=%0h", c, starved, exp_b); end
            next_cycle();
        end
        $display("reset_mid_read: pending response dropped, counter restarted");
        a_req = 1'b0; b_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_b_idle_alternate;
        logic exp_g;
        a_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            exp_g = ((i % 2) == 0);
            b_req = exp_g; b_we = 1'b0; b_addr = 32'(i);
            @(negedge clk);
            total++; if (b_gnt !== exp_g)  begin bad++; $display("FAIL balt_b_gnt i=%0d got=%0h exp=%0h", i, b_gnt, exp_g); end
            total++; if (starved !== 1'b0) begin bad++; $display("FAIL balt_starved i=%0d got=%0h exp=0", i, starved); end
            $display("b_alternate: cycle %0d b_req=%0b b_gnt=%0b", i, b_req, b_gnt);
            next_cycle();
        end
        b_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_a_read();
        test_b_write();
        test_starve();
        test_back_to_back();
        test_reset_mid_read();
        test_b_idle_alternate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dmem_arbiter
